// File: rtl/uart_frame_rx_pkg.sv
// uart_frame_rx_pkg: shared definitions for the UART framing receiver.
//   state_t      : framer FSM states
//   ERR_*        : error codes reported on err_code with frame_err
//   DEF_HEADER   : default start-of-frame byte
package uart_frame_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_DRAIN
  } state_t;

  localparam logic [1:0] ERR_OVERRUN = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEF_HEADER = 8'hAA;

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: DEPTH x 8 simple dual-port payload buffer.
//   clk, rst_n        : clock, async active-low reset (read register only)
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr      : read request; o_rdata updates the following cycle
//   o_rdata           : registered read data, held while i_re is low
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  // Holding the read register when i_re is low keeps the presented byte
  // stable under backpressure.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];

  assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: frames UART bytes as HEADER, LEN, payload[, CSUM] and streams verified payloads.
//   clk, rst_n            : clock, async active-low reset
//   i_rx_data, i_rx_done  : byte and byte-complete level from the UART receiver
//   o_m_data/o_m_valid/i_m_ready/o_m_last : payload stream, o_m_last on final byte
//   o_frame_ok            : one-cycle pulse, frame verified and drain starting
//   o_frame_err/o_err_code: one-cycle error pulse with code (ERR_* in the package)
// Build option UART_FRAME_CSUM_EN: when defined, a trailing checksum byte is
// required so that (LEN + payload + CSUM) mod 256 == 0; otherwise frames end
// after the last payload byte.
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] HEADER      = DEF_HEADER,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  output logic [7:0] o_m_data,
  output logic       o_m_valid,
  input  logic       i_m_ready,
  output logic       o_m_last,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic [1:0] o_err_code
);

  localparam int         AW    = $clog2(MAX_LEN + 1);
  localparam int         TW    = $clog2(TIMEOUT_CYC);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);

  state_t        r_state;
  logic          r_rx_done_q;
  logic [AW-1:0] r_len;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_rd_idx;
  logic [TW-1:0] r_tmo;
  logic          r_m_valid;
  logic          r_m_last;
  logic          r_frame_ok;
  logic          r_frame_err;
  logic [1:0]    r_err_code;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]    r_sum;
  logic [7:0]    w_csum;
`endif

  logic w_byte;
  logic w_mid;
  logic w_tmo_hit;
  logic w_hs;
  logic w_fetch;
  logic w_we;
  logic w_len_bad;
  logic w_last_pay;

  // Rising edge of the rx_done level: a long level counts as one byte.
  assign w_byte     = i_rx_done & ~r_rx_done_q;
  assign w_mid      = r_state inside {S_LEN, S_PAYLOAD, S_CSUM};
  // An accepted byte on the limit cycle takes priority over the timeout.
  assign w_tmo_hit  = w_mid & ~w_byte & (r_tmo == TW'(TIMEOUT_CYC - 1));
  assign w_hs       = r_m_valid & i_m_ready;
  // Fetch the next byte when the output slot is empty or being consumed.
  assign w_fetch    = (r_state == S_DRAIN) & (r_rd_idx != r_len) & (~r_m_valid | w_hs);
  assign w_we       = (r_state == S_PAYLOAD) & w_byte;
  assign w_len_bad  = (i_rx_data == 8'd0) || (i_rx_data > MAX_B);
  assign w_last_pay = r_idx == r_len - AW'(1);
`ifdef UART_FRAME_CSUM_EN
  assign w_csum     = r_sum + i_rx_data;
`endif

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (i_rx_data),
    .i_re    (w_fetch),
    .i_raddr (r_rd_idx),
    .o_rdata (o_m_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rx_done_q <= 1'b0;
      r_len       <= '0;
      r_idx       <= '0;
      r_rd_idx    <= '0;
      r_tmo       <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= '0;
`ifdef UART_FRAME_CSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_rx_done_q <= i_rx_done;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_tmo       <= (w_byte || !w_mid) ? '0 : r_tmo + TW'(1);
      if (w_tmo_hit) begin
        r_frame_err <= 1'b1;
        r_err_code  <= ERR_TIMEOUT;
        r_state     <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE:
            if (w_byte && i_rx_data == HEADER) r_state <= S_LEN;
          S_LEN:
            if (w_byte) begin
              if (w_len_bad) begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_LEN;
                r_state     <= S_IDLE;
              end else begin
                r_len   <= AW'(i_rx_data);
                r_idx   <= '0;
`ifdef UART_FRAME_CSUM_EN
                r_sum   <= i_rx_data;
`endif
                r_state <= S_PAYLOAD;
              end
            end
          S_PAYLOAD:
            if (w_byte) begin
              r_idx <= r_idx + AW'(1);
`ifdef UART_FRAME_CSUM_EN
              r_sum <= w_csum;
              if (w_last_pay) r_state <= S_CSUM;
`else
              if (w_last_pay) begin
                r_frame_ok <= 1'b1;
                r_rd_idx   <= '0;
                r_state    <= S_DRAIN;
              end
`endif
            end
`ifdef UART_FRAME_CSUM_EN
          S_CSUM:
            if (w_byte) begin
              if (w_csum == 8'd0) begin
                r_frame_ok <= 1'b1;
                r_rd_idx   <= '0;
                r_state    <= S_DRAIN;
              end else begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_CSUM;
                r_state     <= S_IDLE;
              end
            end
`endif
          S_DRAIN: begin
            // Bytes arriving during drain are dropped; the drain is unaffected.
            if (w_byte) begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_OVERRUN;
            end
            if (w_fetch) begin
              r_m_valid <= 1'b1;
              r_m_last  <= r_rd_idx == r_len - AW'(1);
              r_rd_idx  <= r_rd_idx + AW'(1);
            end else if (w_hs) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              if (r_m_last) r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_m_valid   = r_m_valid;
  assign o_m_last    = r_m_last;
  assign o_frame_ok  = r_frame_ok;
  assign o_frame_err = r_frame_err;
  assign o_err_code  = r_err_code;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: scoreboard bench for uart_frame_rx (payload beats and ok/err events).
module tb_uart_frame_rx;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_q[$];
  logic [7:0] evt_q[$];
  bit prev_ok = 1'b0;
  bit prev_hs = 1'b0;
  bit prev_last = 1'b0;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .MAX_LEN     (MAX_LEN),
    .HEADER      (8'hAA),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_done   (rx_done),
    .o_m_data    (m_data),
    .o_m_valid   (m_valid),
    .i_m_ready   (m_ready),
    .o_m_last    (m_last),
    .o_frame_ok  (frame_ok),
    .o_frame_err (frame_err),
    .o_err_code  (err_code)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ev(input logic [7:0] e);
    if (evt_q.size() == 0) chk("extra_event", 32'(e), 32'd0);
    else chk("event", 32'(e), 32'(evt_q.pop_front()));
  endtask

  // Outputs are sampled on the falling edge, inputs change just after the rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_ok) chk("ok_to_valid", 32'(m_valid), 32'd1);
      if (prev_hs) chk(prev_last ? "valid_drop" : "no_bubble", 32'(m_valid), 32'(!prev_last));
      prev_ok = frame_ok;
      if (frame_ok) ev(8'h10);
      if (frame_err) ev(8'h20 | {6'd0, err_code});
      if (m_valid) begin
        if (exp_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
        else chk("beat", 32'({m_last, m_data}), 32'(exp_q[0]));
      end
      prev_hs = m_valid && m_ready;
      prev_last = m_last;
      if (prev_hs && exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      prev_ok = 1'b0;
      prev_hs = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    repeat (5) tick();
    rx_done = 1'b0;
    repeat (2) tick();
  endtask

  task automatic send_frame(input int n, input logic [63:0] p, input bit good);
    logic [7:0] s;
    s = 8'(n);
`ifdef UART_FRAME_CSUM_EN
    if (good) begin
`endif
      evt_q.push_back(8'h10);
      for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, p[8*i +: 8]});
`ifdef UART_FRAME_CSUM_EN
    end else evt_q.push_back(8'h22);
`endif
    send_byte(8'hAA);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      send_byte(p[8*i +: 8]);
      s = s + p[8*i +: 8];
    end
`ifdef UART_FRAME_CSUM_EN
    send_byte(good ? 8'h00 - s : 8'h01 - s);
`endif
  endtask

  task automatic wait_evt(input int budget);
    int n = 0;
    while (evt_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("evt_wait", 32'(evt_q.size()), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || evt_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("done_wait", 32'(exp_q.size() + evt_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_ok", 32'(frame_ok), 32'd0);
    chk("rst_err", 32'({frame_err, err_code}), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    send_frame(3, 64'h332211, 1'b1);
    wait_done(100);

`ifdef UART_FRAME_CSUM_EN
    send_frame(3, 64'h332211, 1'b0);
    wait_done(100);
    send_frame(3, 64'h332211, 1'b1);
    wait_done(100);
`endif

    evt_q.push_back(8'h21);
    send_byte(8'hAA);
    send_byte(8'h00);
    wait_done(50);
    evt_q.push_back(8'h21);
    send_byte(8'hAA);
    send_byte(8'h11);
    wait_done(50);

    evt_q.push_back(8'h23);
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h01);
    wait_done(TMO + 20);
    send_frame(1, 64'h5A, 1'b1);
    wait_done(100);

    m_ready = 1'b0;
    send_frame(3, 64'h332211, 1'b1);
    wait_evt(50);
    evt_q.push_back(8'h20);
    send_byte(8'h44);
    wait_evt(50);
    repeat (5) tick();
    m_ready = 1'b1;
    wait_done(100);

    send_byte(8'h55);
    send_byte(8'h00);
    send_frame(2, 64'h0201, 1'b1);
    wait_done(100);

    m_ready = 1'b0;
    send_frame(2, 64'h7766, 1'b1);
    wait_evt(50);
    repeat (3) tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_valid", 32'(m_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    tick();
    send_frame(4, 64'hDDCCBBA0, 1'b1);
    wait_done(100);

    chk("leftover", 32'(exp_q.size() + evt_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
